mapper4510_bus_ctrl: RTL and testbench

//  Downstream consumer of the 4510 mapper output. Decodes the 20-bit mapped address into a
//  RAM, ROM or IO region and runs the bus cycle, including wait states and the IO

---
 rtl/mapper4510_pkg.sv | 37 +++
 rtl/mapper4510_region_decode.sv | 30 +++
 rtl/mapper4510_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_mapper4510_bus_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mapper4510_pkg.sv
// Shared types and constants for the 4510 mapper bus controller.
//   region_t : decoded target region of a mapped address
//   state_t  : bus-cycle FSM state encoding
//   access_t : access fields latched when the controller accepts a request
package mapper4510_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PAGE_W = 8;

  // 4 KiB page that holds the IO devices, and the 64 KiB bank that holds ROM
  localparam logic [PAGE_W-1:0] IO_WINDOW = 8'hFD;
  localparam logic [3:0]        ROM_BANK  = 4'hF;

  localparam logic [DATA_W-1:0] RDATA_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_ROM = 2'd1,
    REG_IO  = 2'd2
  } region_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              mapped;
    region_t           region;
  } access_t;

endpackage

// File: rtl/mapper4510_region_decode.sv
// Combinational region decode of the upper address page.
//   page     in  : addr_next[19:12]
//   region_c out : RAM / ROM / IO region
//   load_c   out : counter load value for that region (wait states or IO timeout)
module mapper4510_region_decode
  import mapper4510_pkg::*;
#(
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic [PAGE_W-1:0] page,
  output region_t           region_c,
  output logic [CNT_W-1:0]  load_c
);

  // IO window takes priority over the enclosing ROM bank
  always_comb begin
    region_c = REG_RAM;
    load_c   = CNT_W'(RAM_WAIT);
    if (page == IO_WINDOW) begin
      region_c = REG_IO;
      load_c   = CNT_W'(IO_TIMEOUT);
    end else if (page[PAGE_W-1 -: 4] == ROM_BANK) begin
      region_c = REG_ROM;
      load_c   = CNT_W'(ROM_WAIT);
    end
  end

endmodule

// File: rtl/mapper4510_bus_ctrl.sv
// Bus-cycle controller downstream of the 4510 mapper.
// Accepts a core access, decodes its region, drives chip selects for the
// region's wait states (or until io_ack / timeout for IO) and returns
// registered read data. ready stalls the core while busy or mapper_busy.
//   clk, reset            : clock, async active-low reset
//   req/we/addr_next/...  : core access request and mapper side info
//   mapper_busy           : mapper fast-table refresh, blocks acceptance
//   bus_rdata, io_ack     : device return path
//   ready                 : combinational, (state==IDLE) & ~mapper_busy
//   rdata, bus_*, cs_*    : registered bus outputs
//   bus_err               : one-cycle pulse after an IO timeout
//   last_mapped           : map_next of the last accepted access
module mapper4510_bus_ctrl
  import mapper4510_pkg::*;
#(
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 15,
  parameter bit          ROM_WP     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_next,
  input  logic              map_next,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mapper_busy,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              io_ack,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              cs_ram,
  output logic              cs_rom,
  output logic              cs_io,
  output logic              bus_err,
  output logic              last_mapped
);

  state_t           state;
  state_t           state_nxt;
  access_t          acc;
  logic [CNT_W-1:0] cnt;

  region_t          dec_region_c;
  logic [CNT_W-1:0] dec_load_c;

  logic             accept_c;
  logic             done_c;
  logic             ack_c;
  logic             timeout_c;
  logic             rom_drop_c;

  mapper4510_region_decode #(
    .RAM_WAIT   (RAM_WAIT),
    .ROM_WAIT   (ROM_WAIT),
    .IO_TIMEOUT (IO_TIMEOUT)
  ) u_decode (
    .page     (addr_next[ADDR_W-1 -: PAGE_W]),
    .region_c (dec_region_c),
    .load_c   (dec_load_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept_c) state_nxt = ST_ACCESS;
      ST_ACCESS: if (done_c)   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs; io_ack is checked before the timeout so it wins a tie
  always_comb begin
    ready     = 1'b0;
    accept_c  = 1'b0;
    done_c    = 1'b0;
    ack_c     = 1'b0;
    timeout_c = 1'b0;
    case (state)
      ST_IDLE: begin
        ready    = !mapper_busy;
        accept_c = req && !mapper_busy;
      end
      ST_ACCESS: begin
        if (acc.region == REG_IO) begin
          if (io_ack) begin
            done_c = 1'b1;
            ack_c  = 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            done_c    = 1'b1;
            timeout_c = 1'b1;
          end
        end else if (cnt == '0) begin
          done_c = 1'b1;
          ack_c  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Write-protected ROM writes still run their wait states but never reach the device
  assign rom_drop_c = ROM_WP && we && (dec_region_c == REG_ROM);

  // Access latches, wait/timeout counter, chip selects and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      rdata   <= RDATA_IDLE;
      cs_ram  <= 1'b0;
      cs_rom  <= 1'b0;
      cs_io   <= 1'b0;
      bus_we  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout_c;
      if (accept_c) begin
        acc.addr   <= addr_next;
        acc.wdata  <= wdata;
        acc.we     <= we;
        acc.mapped <= map_next;
        acc.region <= dec_region_c;
        cnt        <= dec_load_c;
        cs_ram     <= (dec_region_c == REG_RAM);
        cs_rom     <= (dec_region_c == REG_ROM) && !rom_drop_c;
        cs_io      <= (dec_region_c == REG_IO);
        bus_we     <= we && !rom_drop_c;
      end else if (done_c) begin
        cs_ram <= 1'b0;
        cs_rom <= 1'b0;
        cs_io  <= 1'b0;
        bus_we <= 1'b0;
        if (!acc.we) rdata <= ack_c ? bus_rdata : RDATA_IDLE;
      end else if (state == ST_ACCESS) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus_addr    = acc.addr;
  assign bus_wdata   = acc.wdata;
  assign last_mapped = acc.mapped;

endmodule

// File: tb/tb_mapper4510_bus_ctrl.sv
// Directed bench for mapper4510_bus_ctrl with default parameters
// (RAM_WAIT=0, ROM_WAIT=1, IO_TIMEOUT=15, ROM_WP=1).
module tb_mapper4510_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [19:0] addr_next = '0;
  logic        map_next = 1'b0;
  logic [7:0]  wdata = '0;
  logic        mapper_busy = 1'b0;
  logic [7:0]  bus_rdata = '0;
  logic        io_ack = 1'b0;
  logic        ready;
  logic [7:0]  rdata;
  logic [19:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        cs_ram;
  logic        cs_rom;
  logic        cs_io;
  logic        bus_err;
  logic        last_mapped;

  int n_cmp = 0;
  int n_bad = 0;

  mapper4510_bus_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr_next   (addr_next),
    .map_next    (map_next),
    .wdata       (wdata),
    .mapper_busy (mapper_busy),
    .bus_rdata   (bus_rdata),
    .io_ack      (io_ack),
    .ready       (ready),
    .rdata       (rdata),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .cs_ram      (cs_ram),
    .cs_rom      (cs_rom),
    .cs_io       (cs_io),
    .bus_err     (bus_err),
    .last_mapped (last_mapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic        mapped;
    logic [7:0]  wdata;
    logic [7:0]  brd;      // device read data presented during the access
    int          ack_at;   // ACCESS cycle carrying io_ack, 0 = never
    int          cycles;   // expected ACCESS cycles
    logic [2:0]  cs;       // expected {cs_ram, cs_rom, cs_io} during ACCESS
    logic        bwe;      // expected bus_we during ACCESS
    logic [7:0]  rd;       // expected rdata afterwards
    logic        err;      // expected bus_err pulse
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access from IDLE to the first IDLE cycle after it
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int cs_bad;
    int we_bad;
    @(negedge clk);
    check($sformatf("v%0d_ready_idle", idx), 32'(ready), 32'd1);
    req = 1'b1; we = v.we; addr_next = v.addr; map_next = v.mapped;
    wdata = v.wdata; bus_rdata = v.brd;
    @(negedge clk);
    req = 1'b0;
    n = 0; cs_bad = 0; we_bad = 0;
    while (!ready && n < 64) begin
      n++;
      io_ack = (n == v.ack_at);
      if ({cs_ram, cs_rom, cs_io} !== v.cs) cs_bad++;
      if (bus_we !== v.bwe) we_bad++;
      @(negedge clk);
      io_ack = 1'b0;
    end
    check($sformatf("v%0d_cycles", idx), 32'(n), 32'(v.cycles));
    check($sformatf("v%0d_cs_bad", idx), 32'(cs_bad), 32'd0);
    check($sformatf("v%0d_we_bad", idx), 32'(we_bad), 32'd0);
    check($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.rd));
    check($sformatf("v%0d_bus_err", idx), 32'(bus_err), 32'(v.err));
    check($sformatf("v%0d_cs_off", idx), 32'({cs_ram, cs_rom, cs_io, bus_we}), 32'd0);
    check($sformatf("v%0d_bus_addr", idx), 32'(bus_addr), 32'(v.addr));
    check($sformatf("v%0d_bus_wdata", idx), 32'(bus_wdata), 32'(v.wdata));
    check($sformatf("v%0d_last_mapped", idx), 32'(last_mapped), 32'(v.mapped));
    @(negedge clk);
    check($sformatf("v%0d_err_clear", idx), 32'(bus_err), 32'd0);
  endtask

  initial begin
    int bad;

    //        we  addr        map wdata  brd    ack cyc cs      bwe rd     err
    vecs[0] = '{1'b0, 20'h01234, 1'b1, 8'h00, 8'h5A, 0,  1,  3'b100, 1'b0, 8'h5A, 1'b0};
    vecs[1] = '{1'b1, 20'hF8000, 1'b0, 8'h77, 8'h11, 0,  2,  3'b000, 1'b0, 8'h5A, 1'b0};
    vecs[2] = '{1'b0, 20'hFFFFF, 1'b1, 8'h00, 8'h3C, 0,  2,  3'b010, 1'b0, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 20'hEFFFF, 1'b0, 8'hA5, 8'h99, 0,  1,  3'b100, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{1'b0, 20'hFD020, 1'b1, 8'h00, 8'hC3, 3,  3,  3'b001, 1'b0, 8'hC3, 1'b0};
    vecs[5] = '{1'b1, 20'hFDFFF, 1'b0, 8'h12, 8'h00, 1,  1,  3'b001, 1'b1, 8'hC3, 1'b0};
    vecs[6] = '{1'b0, 20'hFD000, 1'b1, 8'h00, 8'h42, 0,  15, 3'b001, 1'b0, 8'hFF, 1'b1};
    vecs[7] = '{1'b0, 20'hFCFFF, 1'b0, 8'h00, 8'h81, 0,  2,  3'b010, 1'b0, 8'h81, 1'b0};
    vecs[8] = '{1'b0, 20'hFE000, 1'b1, 8'h00, 8'h18, 0,  2,  3'b010, 1'b0, 8'h18, 1'b0};
    vecs[9] = '{1'b0, 20'hFD7FF, 1'b0, 8'h00, 8'h6B, 15, 15, 3'b001, 1'b0, 8'h6B, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdata", 32'(rdata), 32'hFF);
    check("rst_cs_we_err", 32'({cs_ram, cs_rom, cs_io, bus_we, bus_err}), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst_last_mapped", 32'(last_mapped), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // mapper_busy for 16 cycles with req held: no acceptance until it falls
    @(negedge clk);
    mapper_busy = 1'b1; req = 1'b1; we = 1'b0; addr_next = 20'h00100;
    map_next = 1'b1; bus_rdata = 8'hD2;
    bad = 0;
    repeat (16) begin
      #1;
      if (ready !== 1'b0 || {cs_ram, cs_rom, cs_io} !== 3'b000) bad++;
      @(negedge clk);
    end
    check("busy_stall_bad", 32'(bad), 32'd0);
    mapper_busy = 1'b0;
    #1;
    check("busy_fall_ready", 32'(ready), 32'd1);
    @(negedge clk);
    req = 1'b0;
    check("busy_cs_start", 32'({cs_ram, cs_rom, cs_io}), 32'b100);
    @(negedge clk);
    check("busy_done_ready", 32'(ready), 32'd1);
    check("busy_rdata", 32'(rdata), 32'hD2);

    // mapper_busy rising mid-access: access completes, ready held low afterwards
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr_next = 20'hFF000; bus_rdata = 8'h5C;
    @(negedge clk);
    req = 1'b0; mapper_busy = 1'b1;
    check("midbusy_cs_rom", 32'(cs_rom), 32'd1);
    repeat (2) @(negedge clk);
    check("midbusy_ready_low", 32'(ready), 32'd0);
    check("midbusy_cs_off", 32'({cs_ram, cs_rom, cs_io}), 32'd0);
    check("midbusy_rdata", 32'(rdata), 32'h5C);
    mapper_busy = 1'b0;
    #1;
    check("midbusy_ready_back", 32'(ready), 32'd1);

    // Reset during an IO access
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr_next = 20'hFD010; bus_rdata = 8'h3A;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rstmid_cs_io_before", 32'(cs_io), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_cs_io", 32'({cs_ram, cs_rom, cs_io, bus_we}), 32'd0);
    check("rstmid_rdata", 32'(rdata), 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      if (bus_err !== 1'b0 || cs_io !== 1'b0 || ready !== 1'b1) bad++;
      @(negedge clk);
    end
    check("rstmid_idle_quiet", 32'(bad), 32'd0);
    check("rstmid_rdata_after", 32'(rdata), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
